ir_cmd_scheduler: RTL and testbench
===================================

Name: ir_cmd_scheduler

Overview:
Sits downstream of the IR remote frame decoder, which produces an 8-bit command and its complement byte per frame, plus a repeat-code pulse. The block has four jobs:
- Validate each frame (command must equal the bitwise inverse of its complement byte).
- Track the button-held window and turn repeat codes into rate-limited auto-repeat events.
- Queue accepted events in a small FIFO.
- Hand events to the consumer over a valid/ready interface.

Parameters:
CMD_W, 8, width of the command and complement fields.
FIFO_DEPTH, 4, number of queued events; must be a power of 2 and at least 2.
REPEAT_WINDOW, 6000000, cycles a frame or repeat keeps the held window open (120 ms at 50 MHz).
REPEAT_SKIP, 2, number of leading repeat codes swallowed before auto-repeat events are emitted.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset.
frame_valid  in  1  one-cycle pulse: cmd_in/cmd_inv_in hold a complete frame.
cmd_in  in  CMD_W  decoded command byte.
cmd_inv_in  in  CMD_W  decoded complement byte.
rpt_valid  in  1  one-cycle pulse: repeat code received.
out_valid  out  1  event available.
out_ready  in  1  consumer accepts the event when out_valid && out_ready.
out_cmd  out  CMD_W  event command.
out_rpt  out  1  event is an auto-repeat (1) or a fresh press (0).
held  out  1  held window open (state != IDLE).
err_pulse  out  1  one-cycle pulse on a rejected frame, a stale repeat, or FIFO overflow.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, FIFO empty, window timer=0, rpt_count=0, last_cmd=0. Outputs out_valid=0, out_cmd=0, out_rpt=0, held=0, err_pulse=0.
- Frame check: a frame is accepted iff cmd_in == ~cmd_inv_in.
- Accepted frame:
  - push {cmd_in, rpt=0};
  - last_cmd <= cmd_in; timer <= REPEAT_WINDOW; rpt_count <= 0; state <= ACTIVE.
  - Applies from any state, including mid-REPEATING.
- Rejected frame: no push; err_pulse=1; state, timer and last_cmd unchanged.
- Repeat in ACTIVE or REPEATING:
  - timer <= REPEAT_WINDOW; state <= REPEATING;
  - rpt_count increments, saturating at REPEAT_SKIP.
  - If the pre-increment rpt_count == REPEAT_SKIP, push {last_cmd, rpt=1}.
  - With REPEAT_SKIP=2: repeats 1–2 are silent; repeat 3 onward each push an event.
- Repeat in IDLE: ignored; err_pulse=1 (stale repeat).
- frame_valid and rpt_valid in the same cycle: the frame is processed and the repeat is discarded, with no error.
- Window timer:
  - decrements by 1 each cycle while nonzero and not being reloaded;
  - the cycle it reaches 0, state <= IDLE and rpt_count <= 0.
  - A reload in the same cycle the timer would expire wins: state stays active.
- State machine:
  - IDLE -> ACTIVE on an accepted frame.
  - ACTIVE -> REPEATING on a repeat.
  - ACTIVE or REPEATING -> IDLE on timer expiry.
  - REPEATING -> ACTIVE on an accepted frame.
- Latency: frame_valid or rpt_valid at edge N produces out_valid=1 after edge N+1 when the FIFO was empty. The output is driven from the registered FIFO head.
- FIFO:
  - Pop occurs on out_valid && out_ready.
  - Push while full and not popping in the same cycle: the event is dropped and err_pulse=1.
  - Push and pop in the same cycle when full: both succeed, occupancy unchanged.
  - Push and pop in the same cycle when empty: impossible, because out_valid=0 while empty.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
- Output stability: out_cmd and out_rpt stay stable while out_valid && !out_ready.
- err_pulse: if several error conditions occur in the same cycle, they OR into a single pulse.

Optional Feature:
IR_STAT_CNT_EN
- Defined: adds the output err_count [15:0], a saturating count of err_pulse cycles (holds at 16'hFFFF), cleared only by reset.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package ir_pkg holds:
  - localparam CMD_W;
  - typedef sched_state_t enum {IDLE, ACTIVE, REPEATING};
  - typedef ir_event_t struct {cmd, rpt}.
- Sub-module ir_cmd_fifo: a synchronous FIFO with registered head, parameterised on FIFO_DEPTH. Push/pop/full/empty are the only interface.
- The scheduler contains the FSM, timer, validation and rate limiting.

Test Plan:
1. Reset mid-operation: 3 events queued, state=REPEATING, assert reset=0 -> out_valid=0, held=0 immediately (asynchronous); after release, IDLE with FIFO empty.
2. Valid frame cmd=8'h45, inv=8'hBA, out_ready=1 -> out_valid one cycle after the pulse, out_cmd=8'h45, out_rpt=0, held=1; no activity for REPEAT_WINDOW cycles -> held=0.
3. Invalid frame cmd=8'h45, inv=8'hBB -> err_pulse=1, no event, held unchanged. A repeat in IDLE -> err_pulse=1, no event.
4. Valid frame 8'h16 then 5 repeats spaced REPEAT_WINDOW/2 apart -> events in order: (16,0), (16,1), (16,1), (16,1), i.e. repeats 3–5 emit. A repeat arriving REPEAT_WINDOW+1 cycles after the last -> stale error, no event.
5. out_ready=0, 5 valid frames 01..05 -> 4 queued; 5th gives err_pulse=1. Release ready -> 01,02,03,04 in order, data stable while stalled.
6. frame_valid (8'h20) and rpt_valid together in REPEATING -> single event (20,0), rpt_count=0, state=ACTIVE, no err_pulse.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared types for the IR command scheduler: command width, scheduler states
// and the queued event record.
package ir_pkg;

  localparam int CMD_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    REPEATING = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic             rpt;
  } ir_event_t;

endpackage

// File: rtl/ir_cmd_fifo.sv
// Small synchronous event FIFO; the head entry is presented directly from
// register storage, so it is stable while not popped.
module ir_cmd_fifo
  import ir_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  ir_event_t push_data,
  input  logic      pop,
  output ir_event_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  ir_event_t       mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ir_cmd_scheduler.sv
// IR command scheduler: frame validation, held-window tracking, rate-limited
// auto-repeat and event queueing. Optional IR_STAT_CNT_EN adds err_count.
module ir_cmd_scheduler
  import ir_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned REPEAT_WINDOW = 6000000,
  parameter int unsigned REPEAT_SKIP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_valid,
  input  logic [CMD_W-1:0] cmd_in,
  input  logic [CMD_W-1:0] cmd_inv_in,
  input  logic             rpt_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CMD_W-1:0] out_cmd,
  output logic             out_rpt,
  output logic             held,
  output logic             err_pulse
`ifdef IR_STAT_CNT_EN
  ,
  output logic [15:0]      err_count
`endif
);

  localparam int unsigned TW  = $clog2(REPEAT_WINDOW + 1);
  localparam int unsigned RCW = (REPEAT_SKIP > 0) ? $clog2(REPEAT_SKIP + 1) : 1;
  localparam logic [TW-1:0]  WINDOW_LD = TW'(REPEAT_WINDOW);
  localparam logic [RCW-1:0] SKIP_CNT  = RCW'(REPEAT_SKIP);

  sched_state_t     state;
  logic [TW-1:0]    timer;
  logic [RCW-1:0]   rpt_count;
  logic [CMD_W-1:0] last_cmd;

  logic      accept, reject, rpt_live, rpt_stale, rpt_emit;
  logic      ev_push, push_q, pop, fifo_full, fifo_empty, overflow;
  ir_event_t ev_data, push_data_q, head;

  always_comb begin
    accept    = frame_valid && (cmd_in == ~cmd_inv_in);
    reject    = frame_valid && (cmd_in != ~cmd_inv_in);
    // A frame in the same cycle shadows the repeat entirely.
    rpt_live  = rpt_valid && !frame_valid && (state != IDLE);
    rpt_stale = rpt_valid && !frame_valid && (state == IDLE);
    rpt_emit  = rpt_live && (rpt_count == SKIP_CNT);
    ev_push   = accept || rpt_emit;
    ev_data   = accept ? '{cmd: cmd_in, rpt: 1'b0} : '{cmd: last_cmd, rpt: 1'b1};
  end

  assign pop       = out_valid && out_ready;
  assign overflow  = push_q && fifo_full && !pop;
  assign out_valid = !fifo_empty;
  assign out_cmd   = head.cmd;
  assign out_rpt   = head.rpt;
  assign held      = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      rpt_count   <= '0;
      last_cmd    <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      err_pulse   <= 1'b0;
    end else begin
      push_q      <= ev_push;
      push_data_q <= ev_data;
      err_pulse   <= reject || rpt_stale || overflow;
      if (accept) begin
        last_cmd  <= cmd_in;
        timer     <= WINDOW_LD;
        rpt_count <= '0;
        state     <= ACTIVE;
      end else if (rpt_live) begin
        timer <= WINDOW_LD;
        state <= REPEATING;
        if (rpt_count != SKIP_CNT) begin
          rpt_count <= rpt_count + 1'b1;
        end
      end else if (timer != '0) begin
        timer <= timer - 1'b1;
        if (timer == TW'(1)) begin
          state     <= IDLE;
          rpt_count <= '0;
        end
      end
    end
  end

`ifdef IR_STAT_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (err_pulse && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

  ir_cmd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// Directed self-checking bench for ir_cmd_scheduler (short window for sim time).
module tb_ir_cmd_scheduler;
  import ir_pkg::*;

  localparam int unsigned RW = 40;

  logic             clk;
  logic             reset;
  logic             frame_valid;
  logic [CMD_W-1:0] cmd_in;
  logic [CMD_W-1:0] cmd_inv_in;
  logic             rpt_valid;
  logic             out_valid;
  logic             out_ready;
  logic [CMD_W-1:0] out_cmd;
  logic             out_rpt;
  logic             held;
  logic             err_pulse;
`ifdef IR_STAT_CNT_EN
  logic [15:0]      err_count;
`endif

  int        n_vec = 0;
  int        n_err = 0;
  ir_event_t mon_q [$];

  ir_cmd_scheduler #(
    .FIFO_DEPTH   (4),
    .REPEAT_WINDOW(RW),
    .REPEAT_SKIP  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_valid(frame_valid),
    .cmd_in     (cmd_in),
    .cmd_inv_in (cmd_inv_in),
    .rpt_valid  (rpt_valid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_cmd    (out_cmd),
    .out_rpt    (out_rpt),
    .held       (held),
    .err_pulse  (err_pulse)
`ifdef IR_STAT_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every handshake; the pop itself happens on the following rising edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) mon_q.push_back('{cmd: out_cmd, rpt: out_rpt});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] ci);
    frame_valid = 1'b1;
    cmd_in      = c;
    cmd_inv_in  = ci;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic send_rpt();
    rpt_valid = 1'b1;
    tick();
    rpt_valid = 1'b0;
  endtask

  task automatic check_event(input string tag, input int idx, input logic [8:0] exp);
    logic [8:0] got;
    got = (idx < mon_q.size()) ? {mon_q[idx].cmd, mon_q[idx].rpt} : 9'h1FF;
    check(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    reset       = 1'b0;
    frame_valid = 1'b0;
    rpt_valid   = 1'b0;
    cmd_in      = '0;
    cmd_inv_in  = '0;
    out_ready   = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_cmd",   32'(out_cmd),   0);
    check("rst_rpt",   32'(out_rpt),   0);
    check("rst_held",  32'(held),      0);
    check("rst_err",   32'(err_pulse), 0);
    #22 reset = 1'b1;
    tick();

    // Valid frame, single event, then window expiry.
    out_ready = 1'b1;
    send_frame(8'h45, 8'hBA);
    check("t2_err0",   32'(err_pulse), 0);
    check("t2_held",   32'(held),      1);
    check("t2_nvalid", 32'(out_valid), 0);
    tick();
    check("t2_valid",  32'(out_valid), 1);
    check("t2_cmd",    32'(out_cmd),   32'h45);
    check("t2_rpt",    32'(out_rpt),   0);
    tick();
    check("t2_popped", 32'(out_valid), 0);
    repeat (RW - 3) tick();
    check("t2_held_last", 32'(held), 1);
    tick();
    check("t2_expired", 32'(held), 0);

    // Rejected frames and stale repeat.
    send_frame(8'h45, 8'hBB);
    check("t3_rej_err",  32'(err_pulse), 1);
    check("t3_rej_held", 32'(held),      0);
    tick();
    check("t3_rej_ev",   32'(out_valid), 0);
    check("t3_err_pulse_len", 32'(err_pulse), 0);
    send_rpt();
    check("t3_stale_err", 32'(err_pulse), 1);
    tick();
    check("t3_stale_ev",  32'(out_valid), 0);
    send_frame(8'h46, 8'hB9);
    tick();
    tick();
    send_frame(8'h46, 8'hBB);
    check("t3_rej_act_err",  32'(err_pulse), 1);
    check("t3_rej_act_held", 32'(held),      1);
    tick();
    check("t3_rej_act_ev",   32'(out_valid), 0);
    repeat (RW + 2) tick();

    // Auto-repeat rate limiting, then stale repeat past the window.
    mon_q.delete();
    send_frame(8'h16, 8'hE9);
    for (int r = 0; r < 5; r++) begin
      repeat (RW / 2 - 1) tick();
      send_rpt();
    end
    repeat (3) tick();
    check("t4_count", 32'(mon_q.size()), 4);
    check_event("t4_ev0", 0, {8'h16, 1'b0});
    check_event("t4_ev1", 1, {8'h16, 1'b1});
    check_event("t4_ev2", 2, {8'h16, 1'b1});
    check_event("t4_ev3", 3, {8'h16, 1'b1});
    repeat (RW - 4) tick();
    check("t4_held_edge", 32'(held), 1);
    tick();
    check("t4_held_off", 32'(held), 0);
    tick();
    send_rpt();
    check("t4_stale_err", 32'(err_pulse), 1);
    tick();
    check("t4_stale_ev", 32'(out_valid), 0);

    // Back-pressure, overflow, ordered drain.
    out_ready = 1'b0;
    mon_q.delete();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), ~8'(i));
    end
    check("t5_no_err_at_full", 32'(err_pulse), 0);
    tick();
    check("t5_ovf_err", 32'(err_pulse), 1);
    check("t5_valid",   32'(out_valid), 1);
    check("t5_head",    32'(out_cmd),   32'h01);
    repeat (3) tick();
    check("t5_stable_cmd", 32'(out_cmd), 32'h01);
    check("t5_stable_rpt", 32'(out_rpt), 0);
    out_ready = 1'b1;
    repeat (6) tick();
    check("t5_count", 32'(mon_q.size()), 4);
    for (int i = 0; i < 4; i++) begin
      check_event("t5_order", i, {8'(i + 1), 1'b0});
    end

    // Frame and repeat together while repeating.
    mon_q.delete();
    send_frame(8'h30, 8'hCF);
    send_rpt();
    check("t6_repeating", 32'(dut.state), 32'(REPEATING));
    frame_valid = 1'b1;
    rpt_valid   = 1'b1;
    cmd_in      = 8'h20;
    cmd_inv_in  = 8'hDF;
    tick();
    frame_valid = 1'b0;
    rpt_valid   = 1'b0;
    check("t6_err",    32'(err_pulse),     0);
    check("t6_state",  32'(dut.state),     32'(ACTIVE));
    check("t6_rcount", 32'(dut.rpt_count), 0);
    repeat (3) tick();
    check("t6_count", 32'(mon_q.size()), 2);
    check_event("t6_ev0", 0, {8'h30, 1'b0});
    check_event("t6_ev1", 1, {8'h20, 1'b0});

    // Asynchronous reset with work in flight.
    out_ready = 1'b0;
    send_frame(8'h0A, 8'hF5);
    send_frame(8'h0B, 8'hF4);
    send_rpt();
    send_rpt();
    send_rpt();
    repeat (2) tick();
    check("t1_pre_valid", 32'(out_valid), 1);
    check("t1_pre_state", 32'(dut.state), 32'(REPEATING));
    #3 reset = 1'b0;
    #1;
    check("t1_async_valid", 32'(out_valid), 0);
    check("t1_async_held",  32'(held),      0);
    check("t1_async_cmd",   32'(out_cmd),   0);
    #2 reset = 1'b1;
    tick();
    check("t1_post_valid", 32'(out_valid), 0);
    check("t1_post_state", 32'(dut.state), 32'(IDLE));
    check("t1_post_err",   32'(err_pulse), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
